// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register: issues a handshaked
// data-memory access, stalls upstream while it is outstanding, resolves branches.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Branch_EX,
  input  logic        MemR_EX,
  input  logic        Mem2R_EX,
  input  logic        MemW_EX,
  input  logic        RegW_EX,
  input  logic        zero,
  input  logic [31:0] PC_EXMEM,
  input  logic [31:0] aluDataOut_EX,
  input  logic [31:0] MEM_rfDataOut2,
  input  logic [4:0]  EX_rfWeSel,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        stall,
  output logic        PCSrc,
  output logic        mem_err,
  output logic        RegW_WB,
  output logic        Mem2R_WB,
  output logic [31:0] memDataOut_WB,
  output logic [31:0] aluDataOut_WB,
  output logic [4:0]  WB_rfWeSel,
  output logic [31:0] PC_WB
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        l_regw, l_mem2r;
  logic [31:0] l_alu, l_pc;
  logic [4:0]  l_rd;

  logic mem_op, misaligned, cnt_last;

  assign mem_op     = MemR_EX | MemW_EX;
  assign misaligned = aluDataOut_EX[1:0] != 2'b00;
  assign cnt_last   = cnt == CNT_LAST;
  assign PCSrc      = Branch_EX & zero;

  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = mem_op & ~misaligned;
    else               stall = ~dm_ack & ~cnt_last;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      mem_err       <= 1'b0;
      RegW_WB       <= 1'b0;
      Mem2R_WB      <= 1'b0;
      memDataOut_WB <= '0;
      aluDataOut_WB <= '0;
      WB_rfWeSel    <= '0;
      PC_WB         <= '0;
      l_regw        <= 1'b0;
      l_mem2r       <= 1'b0;
      l_alu         <= '0;
      l_pc          <= '0;
      l_rd          <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            RegW_WB       <= RegW_EX;
            Mem2R_WB      <= Mem2R_EX;
            aluDataOut_WB <= aluDataOut_EX;
            WB_rfWeSel    <= EX_rfWeSel;
            PC_WB         <= PC_EXMEM;
          end else if (misaligned) begin
            mem_err  <= 1'b1;
            RegW_WB  <= 1'b0;
            Mem2R_WB <= 1'b0;
          end else begin
            state    <= WAIT;
            dm_req   <= 1'b1;
            dm_we    <= MemW_EX;
            dm_addr  <= aluDataOut_EX;
            dm_wdata <= MEM_rfDataOut2;
            cnt      <= '0;
            // WB fields are held here so upstream is free once the access ends
            l_regw   <= RegW_EX;
            l_mem2r  <= Mem2R_EX;
            l_alu    <= aluDataOut_EX;
            l_rd     <= EX_rfWeSel;
            l_pc     <= PC_EXMEM;
            RegW_WB  <= 1'b0;
            Mem2R_WB <= 1'b0;
          end
        end
        WAIT: begin
          if (dm_ack) begin
            state         <= IDLE;
            dm_req        <= 1'b0;
            RegW_WB       <= l_regw;
            Mem2R_WB      <= l_mem2r;
            aluDataOut_WB <= l_alu;
            WB_rfWeSel    <= l_rd;
            PC_WB         <= l_pc;
            if (!dm_we) memDataOut_WB <= dm_rdata;
          end else if (cnt_last) begin
            state    <= IDLE;
            dm_req   <= 1'b0;
            mem_err  <= 1'b1;
            RegW_WB  <= 1'b0;
            Mem2R_WB <= 1'b0;
          end else begin
            cnt      <= cnt + 8'd1;
            RegW_WB  <= 1'b0;
            Mem2R_WB <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (TIMEOUT=4): ALU pass-through, branch,
// load/store handshake, misalignment, timeout with late ack, async reset mid-access.
module tb_mem_wb_stage;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Branch_EX, MemR_EX, Mem2R_EX, MemW_EX, RegW_EX, zero;
  logic [31:0] PC_EXMEM, aluDataOut_EX, MEM_rfDataOut2, dm_rdata;
  logic [4:0]  EX_rfWeSel;
  logic        dm_ack;
  logic        dm_req, dm_we, stall, PCSrc, mem_err, RegW_WB, Mem2R_WB;
  logic [31:0] dm_addr, dm_wdata, memDataOut_WB, aluDataOut_WB, PC_WB;
  logic [4:0]  WB_rfWeSel;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Branch_EX(Branch_EX), .MemR_EX(MemR_EX), .Mem2R_EX(Mem2R_EX),
    .MemW_EX(MemW_EX), .RegW_EX(RegW_EX), .zero(zero),
    .PC_EXMEM(PC_EXMEM), .aluDataOut_EX(aluDataOut_EX),
    .MEM_rfDataOut2(MEM_rfDataOut2), .EX_rfWeSel(EX_rfWeSel),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .stall(stall), .PCSrc(PCSrc), .mem_err(mem_err),
    .RegW_WB(RegW_WB), .Mem2R_WB(Mem2R_WB), .memDataOut_WB(memDataOut_WB),
    .aluDataOut_WB(aluDataOut_WB), .WB_rfWeSel(WB_rfWeSel), .PC_WB(PC_WB)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nop_inputs();
    Branch_EX = 0; MemR_EX = 0; Mem2R_EX = 0; MemW_EX = 0; RegW_EX = 0; zero = 0;
    PC_EXMEM = 0; aluDataOut_EX = 0; MEM_rfDataOut2 = 0; EX_rfWeSel = 0;
  endtask

  task automatic edge_settle();
    @(posedge Clk); #1;
  endtask

  initial begin
    nop_inputs();
    dm_ack = 0; dm_rdata = 0;
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #1;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_regw_wb", RegW_WB, 0);
    chk("rst_pc_wb", PC_WB, 0);
    chk("rst_memdata_wb", memDataOut_WB, 0);
    @(negedge Clk); Rst_n = 1'b1;

    // ALU op straight through
    @(negedge Clk);
    RegW_EX = 1; aluDataOut_EX = 32'h12; EX_rfWeSel = 5; PC_EXMEM = 32'h40;
    #1 chk("alu_stall", stall, 0);
    edge_settle();
    chk("alu_regw_wb", RegW_WB, 1);
    chk("alu_data_wb", aluDataOut_WB, 32'h12);
    chk("alu_rd_wb", WB_rfWeSel, 5);
    chk("alu_pc_wb", PC_WB, 32'h40);
    chk("alu_dm_req", dm_req, 0);

    // Branch resolution is combinational
    @(negedge Clk);
    nop_inputs();
    Branch_EX = 1; zero = 1;
    #1 chk("br_taken", PCSrc, 1);
    zero = 0;
    #1 chk("br_not_taken", PCSrc, 0);

    // Load at 0x100, ack in the third dm_req cycle
    @(negedge Clk);
    nop_inputs();
    MemR_EX = 1; Mem2R_EX = 1; RegW_EX = 1; aluDataOut_EX = 32'h100;
    EX_rfWeSel = 7; PC_EXMEM = 32'h44;
    #1 chk("ld_stall_c0", stall, 1);
    chk("ld_req_c0", dm_req, 0);
    edge_settle();
    chk("ld_req_c1", dm_req, 1);
    chk("ld_addr", dm_addr, 32'h100);
    chk("ld_we", dm_we, 0);
    chk("ld_bubble_c1", RegW_WB, 0);
    @(negedge Clk); #1 chk("ld_stall_c1", stall, 1);
    edge_settle();
    chk("ld_req_c2", dm_req, 1);
    chk("ld_bubble_c2", RegW_WB, 0);
    @(negedge Clk); #1 chk("ld_stall_c2", stall, 1);
    chk("ld_addr_held", dm_addr, 32'h100);
    edge_settle();
    chk("ld_req_c3", dm_req, 1);
    @(negedge Clk);
    dm_ack = 1; dm_rdata = 32'hDEADBEEF;
    #1 chk("ld_stall_ack", stall, 0);
    edge_settle();
    chk("ld_req_done", dm_req, 0);
    chk("ld_memdata_wb", memDataOut_WB, 32'hDEADBEEF);
    chk("ld_mem2r_wb", Mem2R_WB, 1);
    chk("ld_regw_wb", RegW_WB, 1);
    chk("ld_rd_wb", WB_rfWeSel, 7);
    chk("ld_pc_wb", PC_WB, 32'h44);
    @(negedge Clk);
    dm_ack = 0; nop_inputs();
    edge_settle();
    chk("ld_single_wb", RegW_WB, 0);
    chk("ld_no_reissue", dm_req, 0);

    // Store 0x55 to 0x20, ack after two dm_req cycles
    @(negedge Clk);
    MemW_EX = 1; aluDataOut_EX = 32'h20; MEM_rfDataOut2 = 32'h55; PC_EXMEM = 32'h48;
    edge_settle();
    chk("st_req", dm_req, 1);
    chk("st_we", dm_we, 1);
    chk("st_addr", dm_addr, 32'h20);
    chk("st_wdata", dm_wdata, 32'h55);
    edge_settle();
    chk("st_wdata_held", dm_wdata, 32'h55);
    chk("st_we_held", dm_we, 1);
    @(negedge Clk);
    dm_ack = 1; dm_rdata = 32'h99;
    edge_settle();
    chk("st_req_done", dm_req, 0);
    chk("st_regw_wb", RegW_WB, 0);
    chk("st_memdata_kept", memDataOut_WB, 32'hDEADBEEF);
    chk("st_pc_wb", PC_WB, 32'h48);
    @(negedge Clk);
    dm_ack = 0; nop_inputs();

    // Misaligned load
    MemR_EX = 1; Mem2R_EX = 1; RegW_EX = 1; aluDataOut_EX = 32'h102;
    #1 chk("mis_stall", stall, 0);
    edge_settle();
    chk("mis_req", dm_req, 0);
    chk("mis_err", mem_err, 1);
    chk("mis_regw_wb", RegW_WB, 0);
    chk("mis_mem2r_wb", Mem2R_WB, 0);
    @(negedge Clk);
    nop_inputs();
    edge_settle();
    chk("mis_err_pulse", mem_err, 0);

    // Timeout: no ack, TIMEOUT=4
    @(negedge Clk);
    MemR_EX = 1; Mem2R_EX = 1; RegW_EX = 1; aluDataOut_EX = 32'h200;
    edge_settle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk); #1;
      chk($sformatf("to_req_c%0d", i), dm_req, 1);
      chk($sformatf("to_stall_c%0d", i), stall, (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_err_c%0d", i), mem_err, 0);
    end
    edge_settle();
    chk("to_req_drop", dm_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_bubble", RegW_WB, 0);
    @(negedge Clk);
    nop_inputs();
    dm_ack = 1; dm_rdata = 32'h1234;
    edge_settle();
    chk("late_ack_req", dm_req, 0);
    chk("late_ack_err", mem_err, 0);
    chk("late_ack_regw", RegW_WB, 0);
    chk("late_ack_memdata", memDataOut_WB, 32'hDEADBEEF);
    @(negedge Clk);
    dm_ack = 0;

    // Async reset in the middle of an access
    MemR_EX = 1; RegW_EX = 1; aluDataOut_EX = 32'h300;
    edge_settle();
    chk("rw_req_before", dm_req, 1);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("rw_req", dm_req, 0);
    chk("rw_addr", dm_addr, 0);
    chk("rw_memdata", memDataOut_WB, 0);
    chk("rw_pc_wb", PC_WB, 0);
    @(negedge Clk);
    nop_inputs();
    Rst_n = 1'b1;
    dm_ack = 1; dm_rdata = 32'hCAFE;
    edge_settle();
    chk("rw_ack_ignored_req", dm_req, 0);
    chk("rw_ack_ignored_data", memDataOut_WB, 0);
    @(negedge Clk);
    dm_ack = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
